instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly downstream of the program counter. It issues instruction-memory reads at the current PC and handles the variable-latency ihit handshake. It computes the next-PC value (sequential or redirected) and asserts the PC write enable, and it owns the IF/ID pipeline register, including stall and flush handling.

## Interface
Parameters:
- none; all widths come from cpu_types_pkg (word_t = 32 bits).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, synchronous, active-high; sampled on the rising edge of CLK.
- pc  in  32  current PC from the program counter.
- npc  in  32  pc + 4 from the program counter.
- PCen  out  1  PC write enable to the program counter.
- cpc  out  32  next PC value loaded by the program counter when PCen=1.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction read address.
- ihit  in  1  read complete this cycle; imemload valid.
- imemload  in  32  instruction data.
- stall  in  1  hazard unit: IF/ID must hold its contents.
- flush  in  1  branch/jump resolved taken; discard the younger instruction.
- redirect_pc  in  32  target PC, valid when flush=1.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_npc  out  32  IF/ID pc+4 of that instruction.

## Operation
State machine (fetch_state_t): FETCH, HOLD, DRAIN.

FETCH:
- imemREN=1, imemaddr=pc.
- flush: clear ifid_valid. If ihit, PCen=1 and cpc=redirect_pc; stay in FETCH. If not ihit, save redirect_pc in tgt_q and go to DRAIN; PCen=0.
- ihit and not stall: load IF/ID with {1, imemload, npc}; PCen=1, cpc=npc.
- ihit and stall: capture {imemload, npc} in the skid register; PCen=1, cpc=npc; go to HOLD. IF/ID is unchanged.
- no ihit and no flush: PCen=0; all state holds.

HOLD:
- imemREN=0.
- flush: drop the skid, clear ifid_valid, PCen=1, cpc=redirect_pc, go to FETCH.
- not stall: move the skid into IF/ID with valid=1; go to FETCH.
- stall: hold.

DRAIN (an outstanding read cannot be abandoned):
- imemREN=1, imemaddr=pc (old address).
- ihit: discard imemload; PCen=1, cpc=tgt_q; go to FETCH.
- flush in DRAIN: overwrite tgt_q with redirect_pc. If ihit in the same cycle, cpc uses the new redirect_pc.

General rules:
- Priority: RST > flush > stall > normal flow.
- flush clears ifid_valid even while stall=1.
- cpc[1:0] is always forced to 2'b00.
- Arithmetic: none is done locally; npc comes from the program counter. No wrap detection; 0xFFFFFFFC + 4 = 0x00000000 is accepted as-is.

## Timing
- ihit is combinational within the cycle. IF/ID, skid, tgt_q and state update on the CLK edge.
- Best-case latency: an instruction fetched in cycle N (ihit=1) appears on ifid_* in cycle N+1. Throughput is one instruction per cycle when ihit is tied high.
- PCen is combinational. The program counter updates pc on the same edge that IF/ID loads.
- Reset values, at the first edge with RST=1: state=FETCH, ifid_valid=0, ifid_instr=0, ifid_npc=0, skid empty, tgt_q=0.
- Combinational outputs while RST=1: PCen=0, imemREN=0.
- RST during DRAIN or HOLD drops the pending work immediately, with no further discards.
- ifid_instr and ifid_npc are don't-care while ifid_valid=0, but must hold their last value (no X).

## Structure
- cpu_types_pkg gains fetch_state_t (2-bit enum: FETCH, HOLD, DRAIN) and ifid_t (a packed struct {valid, instr, npc}).
- The only natural sub-module is ifid_register: CLK and RST, load/clear controls, holding one ifid_t.
- The FSM, skid register, tgt_q and PC-select logic live in instruction_fetch.

## Test plan
- Reset, then ihit tied 1, pc starting at 0x0: PCen=1 every cycle, cpc=0x4, 0x8, …; ifid_npc=0x4 one cycle after the fetch of 0x0; ifid_valid=1 from the second cycle.
- ihit low for 3 cycles at pc=0x10: imemREN stays 1, PCen=0, IF/ID unchanged; on ihit, IF/ID gets ifid_npc=0x14 on the next edge.
- stall=1 when ihit returns at pc=0x20: PCen=1, cpc=0x24, state=HOLD, IF/ID unchanged. Then stall=0: IF/ID gets imemload and ifid_npc=0x24; state returns to FETCH.
- flush=1 with redirect_pc=0x100 while the read at 0x30 is pending (ihit=0): ifid_valid goes 0, state=DRAIN. A later ihit data is discarded; cpc=0x100 and PCen=1 on that cycle.
- flush=1 with redirect_pc=0x200 during HOLD while stall=1: the skid is dropped, ifid_valid=0, cpc=0x200, state=FETCH.
- RST asserted during DRAIN: the next cycle shows state=FETCH, ifid_valid=0, PCen=0 while RST=1, and no discard occurs after RST drops.

Source files
------------

// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_types_pkg
// Brief    : Shared CPU word type, fetch FSM states and IF/ID register layout.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t C_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic  valid;
      word_t instr;
      word_t npc;
   } ifid_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
//------------------------------------------------------------------------------
// Module   : instruction_fetch_if
// Brief    : PC, instruction-memory, hazard and IF/ID signals of the fetch stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_if;
   import cpu_types_pkg::*;

   word_t pc;
   word_t npc;
   logic  PCen;
   word_t cpc;
   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;
   logic  stall;
   logic  flush;
   word_t redirect_pc;
   logic  ifid_valid;
   word_t ifid_instr;
   word_t ifid_npc;

   // The fetch stage itself.
   modport master (
      input  pc, npc, ihit, imemload, stall, flush, redirect_pc,
      output PCen, cpc, imemREN, imemaddr, ifid_valid, ifid_instr, ifid_npc
   );

   // Surrounding pipeline: program counter, memory, hazard unit, decode.
   modport slave (
      output pc, npc, ihit, imemload, stall, flush, redirect_pc,
      input  PCen, cpc, imemREN, imemaddr, ifid_valid, ifid_instr, ifid_npc
   );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_ifid_register.sv
//------------------------------------------------------------------------------
// Module   : ifid_register
// Brief    : IF/ID pipeline register; clear drops valid but keeps the payload.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifid_register
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  load,
   input  logic  clear,
   input  ifid_t d,
   output ifid_t q
);

   ifid_t ifid_d;
   ifid_t ifid_q;

   always_comb begin
      ifid_d = ifid_q;
      if (clear) begin
         ifid_d.valid = 1'b0;
      end else if (load) begin
         ifid_d = d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ifid_q <= '0;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign q = ifid_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// Module   : instruction_fetch
// Brief    : Fetch stage: imem handshake, next-PC select, skid and IF/ID control.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch
   import cpu_types_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   instruction_fetch_if.master fif
);

   fetch_state_t state_d, state_q;
   word_t        skid_instr_d, skid_instr_q;
   word_t        skid_npc_d, skid_npc_q;
   word_t        tgt_d, tgt_q;

   logic         pc_en;
   word_t        cpc_sel;
   logic         mem_ren;
   logic         ifid_load;
   logic         ifid_clear;
   ifid_t        ifid_in;
   ifid_t        ifid_out;

   always_comb begin
      state_d      = state_q;
      skid_instr_d = skid_instr_q;
      skid_npc_d   = skid_npc_q;
      tgt_d        = tgt_q;
      pc_en        = 1'b0;
      cpc_sel      = fif.npc;
      mem_ren      = 1'b0;
      ifid_load    = 1'b0;
      ifid_clear   = 1'b0;
      ifid_in      = '{valid: 1'b1, instr: fif.imemload, npc: fif.npc};

      if (!RST) begin
         unique case (state_q)
            FETCH: begin
               mem_ren = 1'b1;
               if (fif.flush) begin
                  ifid_clear = 1'b1;
                  if (fif.ihit) begin
                     pc_en   = 1'b1;
                     cpc_sel = fif.redirect_pc;
                  end else begin
                     tgt_d   = fif.redirect_pc;
                     state_d = DRAIN;
                  end
               end else if (fif.ihit) begin
                  pc_en = 1'b1;
                  if (fif.stall) begin
                     skid_instr_d = fif.imemload;
                     skid_npc_d   = fif.npc;
                     state_d      = HOLD;
                  end else begin
                     ifid_load = 1'b1;
                  end
               end
            end
            HOLD: begin
               // PC already advanced when the skid was captured.
               if (fif.flush) begin
                  ifid_clear = 1'b1;
                  pc_en      = 1'b1;
                  cpc_sel    = fif.redirect_pc;
                  state_d    = FETCH;
               end else if (!fif.stall) begin
                  ifid_load = 1'b1;
                  ifid_in   = '{valid: 1'b1, instr: skid_instr_q, npc: skid_npc_q};
                  state_d   = FETCH;
               end
            end
            DRAIN: begin
               // The wrong-path read must complete before the target is fetched.
               mem_ren = 1'b1;
               if (fif.flush) begin
                  ifid_clear = 1'b1;
                  tgt_d      = fif.redirect_pc;
               end
               if (fif.ihit) begin
                  pc_en   = 1'b1;
                  cpc_sel = fif.flush ? fif.redirect_pc : tgt_q;
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= FETCH;
         skid_instr_q <= '0;
         skid_npc_q   <= '0;
         tgt_q        <= '0;
      end else begin
         state_q      <= state_d;
         skid_instr_q <= skid_instr_d;
         skid_npc_q   <= skid_npc_d;
         tgt_q        <= tgt_d;
      end
   end

   ifid_register u_ifid (
      .CLK   (CLK),
      .RST   (RST),
      .load  (ifid_load),
      .clear (ifid_clear),
      .d     (ifid_in),
      .q     (ifid_out)
   );

   assign fif.PCen       = pc_en;
   assign fif.cpc        = cpc_sel & C_ALIGN_MASK;
   assign fif.imemREN    = mem_ren;
   assign fif.imemaddr   = fif.pc;
   assign fif.ifid_valid = ifid_out.valid;
   assign fif.ifid_instr = ifid_out.instr;
   assign fif.ifid_npc   = ifid_out.npc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_instruction_fetch
// Brief    : Randomised bench for instruction_fetch against a queue-based model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;
   import cpu_types_pkg::*;

   localparam int N_CYCLES = 3000;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   instruction_fetch_if fif();

   instruction_fetch dut (
      .CLK (CLK),
      .RST (RST),
      .fif (fif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a buffered instruction waiting for decode, and a
   // redirect target waiting for a wrong-path read to return.
   logic [31:0] skid_instr[$];
   logic [31:0] skid_npc[$];
   logic [31:0] drain_tgt[$];
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_npc;

   logic [31:0] pc_cur;
   logic [31:0] pc_next;

   logic        e_pcen;
   logic [31:0] e_cpc;
   logic        e_ren;
   logic [31:0] tgt;

   initial begin
      m_valid = 1'b0;
      m_instr = '0;
      m_npc   = '0;
      pc_next = '0;
      fif.pc = '0; fif.npc = 32'h4; fif.ihit = 1'b0; fif.imemload = '0;
      fif.stall = 1'b0; fif.flush = 1'b0; fif.redirect_pc = '0;

      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(posedge CLK);
         #1;
         pc_cur          = pc_next;
         RST             = (cyc < 3) || ($urandom_range(0, 99) < 2);
         fif.pc          = pc_cur;
         fif.npc         = pc_cur + 32'd4;
         fif.ihit        = ($urandom_range(0, 99) < 60);
         fif.stall       = ($urandom_range(0, 99) < 30);
         fif.flush       = ($urandom_range(0, 99) < 12);
         fif.imemload    = $urandom;
         fif.redirect_pc = $urandom;

         @(negedge CLK);
         check_val("ifid_valid", {31'd0, fif.ifid_valid}, {31'd0, m_valid});
         check_val("ifid_instr", fif.ifid_instr, m_instr);
         check_val("ifid_npc",   fif.ifid_npc,   m_npc);

         e_pcen = 1'b0;
         e_cpc  = '0;
         e_ren  = 1'b0;
         if (RST) begin
            skid_instr.delete();
            skid_npc.delete();
            drain_tgt.delete();
            m_valid = 1'b0;
            m_instr = '0;
            m_npc   = '0;
         end else if (drain_tgt.size() != 0) begin
            e_ren = 1'b1;
            tgt   = fif.flush ? fif.redirect_pc : drain_tgt[0];
            if (fif.flush) m_valid = 1'b0;
            if (fif.ihit) begin
               e_pcen = 1'b1;
               e_cpc  = tgt;
               drain_tgt.delete();
            end else begin
               drain_tgt[0] = tgt;
            end
         end else if (skid_instr.size() != 0) begin
            if (fif.flush) begin
               skid_instr.delete();
               skid_npc.delete();
               m_valid = 1'b0;
               e_pcen  = 1'b1;
               e_cpc   = fif.redirect_pc;
            end else if (!fif.stall) begin
               m_valid = 1'b1;
               m_instr = skid_instr.pop_front();
               m_npc   = skid_npc.pop_front();
            end
         end else begin
            e_ren = 1'b1;
            if (fif.flush) begin
               m_valid = 1'b0;
               if (fif.ihit) begin
                  e_pcen = 1'b1;
                  e_cpc  = fif.redirect_pc;
               end else begin
                  drain_tgt.push_back(fif.redirect_pc);
               end
            end else if (fif.ihit) begin
               e_pcen = 1'b1;
               e_cpc  = pc_cur + 32'd4;
               if (fif.stall) begin
                  skid_instr.push_back(fif.imemload);
                  skid_npc.push_back(pc_cur + 32'd4);
               end else begin
                  m_valid = 1'b1;
                  m_instr = fif.imemload;
                  m_npc   = pc_cur + 32'd4;
               end
            end
         end
         e_cpc = {e_cpc[31:2], 2'b00};

         check_val("PCen",    {31'd0, fif.PCen},    {31'd0, e_pcen});
         check_val("imemREN", {31'd0, fif.imemREN}, {31'd0, e_ren});
         if (e_ren)  check_val("imemaddr", fif.imemaddr, pc_cur);
         if (e_pcen) check_val("cpc",      fif.cpc,      e_cpc);

         // Restart near the top of the address space sometimes to cover wrap.
         if (RST)         pc_next = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0;
         else if (e_pcen) pc_next = e_cpc;
         else             pc_next = pc_cur;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
